// File: rtl/fp_mul_arbiter.sv
// Two-port round-robin front end sharing a single combinational IEEE-754
// single-precision multiplier; one operation in flight at a time.

module fp_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    logic               sign;
    logic [7:0]         ea, eb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0]        ma, mb;
    logic [47:0]        prod;
    logic               norm, guard, sticky, inc;
    logic [22:0]        mant;
    logic [23:0]        mant_r;
    logic signed [9:0]  e;

    always_comb begin
        sign   = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        a_nan  = (ea == 8'hFF) && (a[22:0] != '0);
        b_nan  = (eb == 8'hFF) && (b[22:0] != '0);
        a_inf  = (ea == 8'hFF) && (a[22:0] == '0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == '0);
        // Denormal inputs are flushed to zero.
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        ma     = {1'b1, a[22:0]};
        mb     = {1'b1, b[22:0]};
        prod   = {24'b0, ma} * {24'b0, mb};
        norm   = prod[47];
        if (norm) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        inc    = guard && (sticky || mant[0]);
        mant_r = {1'b0, mant} + {23'b0, inc};
        e      = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127
                 + (norm ? 10'sd1 : 10'sd0);
        if (mant_r[23]) e = e + 10'sd1;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            p = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            p = {sign, 8'hFF, 23'b0};
        else if (a_zero || b_zero)
            p = {sign, 31'b0};
        else if (e >= 10'sd255)
            p = {sign, 8'hFF, 23'b0};
        else if (e <= 10'sd0)
            p = {sign, 31'b0};
        else
            p = {sign, e[7:0], mant_r[22:0]};
    end

endmodule

module fp_mul_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        busy,
    output logic        gnt_id
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] opa, opb, product;
    logic        rr_ptr;
    logic        pick;

    // A lone requester wins outright; a tie goes to rr_ptr.
    assign pick = (req0 && req1) ? rr_ptr : req1;
    assign busy = (state != IDLE);

    fp_mul u_fp_mul (
        .a (opa),
        .b (opb),
        .p (product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            rr_ptr <= 1'b0;
            gnt_id <= 1'b0;
            result <= '0;
            done0  <= 1'b0;
            done1  <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_id <= pick;
                        opa    <= pick ? a1 : a0;
                        opb    <= pick ? b1 : b0;
                        cnt    <= 4'(LATENCY - 1);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        result <= product;
                        state  <= RESP;
                        if (gnt_id) done1 <= 1'b1;
                        else        done0 <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    rr_ptr <= ~gnt_id;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: expected (port, product) pairs are
// queued in grant order and retired by a monitor on every done pulse.

module tb_fp_mul_arbiter;

    localparam int LAT = 2;

    typedef struct packed {
        logic        port;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        done0, done1, busy, gnt_id;
    logic [31:0] result;
    logic        l1_done0, l1_done1, l1_busy, l1_gnt_id;
    logic [31:0] l1_result;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    exp_t sb[$];

    fp_mul_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .result(result),
        .busy(busy), .gnt_id(gnt_id)
    );

    fp_mul_arbiter #(.LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .done0(l1_done0), .done1(l1_done1), .result(l1_result),
        .busy(l1_busy), .gnt_id(l1_gnt_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done0 || done1) begin
            exp_t e;
            done_cnt++;
            done_cyc = cyc;
            tests++;
            if (done0 && done1) begin
                fails++;
                $display("FAIL both_done: done0=%b done1=%b, required at most one high", done0, done1);
            end
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done0=%b done1=%b result=%h, no operation expected", done0, done1, result);
            end else begin
                e = sb.pop_front();
                if (done1 !== e.port || result !== e.res)
                    begin
                        fails++;
                        $display("FAIL done_result: port=%b result=%h, required port=%b result=%h", done1, result, e.port, e.res);
                    end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done_cnt >= target) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests++; if (done0 !== 1'b0)   begin fails++; $display("FAIL reset_done0: got %b, required 0", done0); end
        tests++; if (done1 !== 1'b0)   begin fails++; $display("FAIL reset_done1: got %b, required 0", done1); end
        tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h, required 0", result); end
        tests++; if (gnt_id !== 1'b0)  begin fails++; $display("FAIL reset_gnt: got %b, required 0", gnt_id); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int t0;
        bit ok;
        do_reset();
        a0 = 32'h4000_0000; b0 = 32'h4040_0000; req0 = 1'b1;
        sb.push_back('{1'b0, 32'h40C0_0000});
        t0 = cyc;
        step();
        tests++; if (busy !== 1'b1 || gnt_id !== 1'b0) begin fails++; $display("FAIL single_grant: busy=%b gnt=%b, required busy=1 gnt=0", busy, gnt_id); end
        wait_done(done_cnt + 1, ok);
        req0 = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL single_timeout: no done seen, required one"); end
        tests++; if (done_cyc - t0 !== LAT + 1) begin fails++; $display("FAIL single_latency: got %0d, required %0d", done_cyc - t0, LAT + 1); end
        repeat (4) step();
        tests++; if (result !== 32'h40C0_0000) begin fails++; $display("FAIL result_hold: got %h, required 40c00000", result); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: busy=%b, required 0", busy); end
    endtask

    task automatic test_simultaneous();
        int d0;
        bit ok;
        do_reset();
        a0 = 32'h3F80_0000; b0 = 32'h3F80_0000; req0 = 1'b1;
        a1 = 32'h4000_0000; b1 = 32'h4040_0000; req1 = 1'b1;
        sb.push_back('{1'b0, 32'h3F80_0000});
        sb.push_back('{1'b1, 32'h40C0_0000});
        wait_done(done_cnt + 1, ok);
        req0 = 1'b0;
        d0 = done_cyc;
        tests++; if (!ok) begin fails++; $display("FAIL simul_timeout0: no done seen, required one"); end
        wait_done(done_cnt + 1, ok);
        req1 = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL simul_timeout1: no done seen, required one"); end
        tests++; if (done_cyc - d0 !== LAT + 2) begin fails++; $display("FAIL simul_spacing: got %0d, required %0d", done_cyc - d0, LAT + 2); end
    endtask

    task automatic test_back_to_back();
        int prev;
        bit ok;
        do_reset();
        a0 = 32'h3FC0_0000; b0 = 32'h4000_0000; req0 = 1'b1;
        a1 = 32'hC000_0000; b1 = 32'h3F00_0000; req1 = 1'b1;
        for (int i = 0; i < 4; i++)
            sb.push_back('{(i % 2 == 1), ((i % 2 == 1) ? 32'hBF80_0000 : 32'h4040_0000)});
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_done(done_cnt + 1, ok);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tests++; if (!ok) begin fails++; $display("FAIL fair_timeout%0d: no done seen, required one", i); end
            if (i > 0) begin
                tests++; if (done_cyc - prev !== LAT + 2) begin fails++; $display("FAIL fair_spacing%0d: got %0d, required %0d", i, done_cyc - prev, LAT + 2); end
            end
            prev = done_cyc;
        end
    endtask

    task automatic test_operand_stability();
        bit ok;
        do_reset();
        a0 = 32'h4040_0000; b0 = 32'h40A0_0000; req0 = 1'b1;
        sb.push_back('{1'b0, 32'h4170_0000});
        step();
        a0 = 32'h0; b0 = 32'h0;
        wait_done(done_cnt + 1, ok);
        req0 = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL stable_timeout: no done seen, required one"); end
        step();
    endtask

    task automatic test_reset_abort();
        int n;
        a0 = 32'h4000_0000; b0 = 32'h4000_0000; req0 = 1'b1;
        repeat (LAT) step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b, required 1", busy); end
        reset = 1'b1;
        req0 = 1'b0;
        n = done_cnt;
        step();
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL abort_busy: got %b, required 0", busy); end
        tests++; if (result !== 32'h0) begin fails++; $display("FAIL abort_result: got %h, required 0", result); end
        reset = 1'b0;
        repeat (6) step();
        tests++; if (done_cnt !== n) begin fails++; $display("FAIL abort_done: got %0d pulses, required %0d", done_cnt, n); end
    endtask

    task automatic test_reset_regrant();
        bit ok;
        do_reset();
        a0 = 32'h4000_0000; b0 = 32'h4040_0000; req0 = 1'b1;
        sb.push_back('{1'b0, 32'h40C0_0000});
        wait_done(done_cnt + 1, ok);
        req0 = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL regrant_timeout0: no done seen, required one"); end
        step();
        a0 = 32'h3F80_0000; b0 = 32'h3F80_0000; req0 = 1'b1;
        a1 = 32'h4040_0000; b1 = 32'h40A0_0000; req1 = 1'b1;
        step();
        tests++; if (gnt_id !== 1'b1) begin fails++; $display("FAIL rr_grant: got %b, required 1", gnt_id); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL regrant_abort: busy=%b, required 0", busy); end
        sb.push_back('{1'b0, 32'h3F80_0000});
        sb.push_back('{1'b1, 32'h4170_0000});
        wait_done(done_cnt + 1, ok);
        req0 = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL regrant_timeout1: no done seen, required one"); end
        wait_done(done_cnt + 1, ok);
        req1 = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL regrant_timeout2: no done seen, required one"); end
    endtask

    task automatic test_latency1();
        bit ok;
        do_reset();
        a0 = 32'h4000_0000; b0 = 32'h4040_0000; req0 = 1'b1;
        sb.push_back('{1'b0, 32'h40C0_0000});
        step();
        tests++; if (l1_busy !== 1'b1 || l1_done0 !== 1'b0) begin fails++; $display("FAIL lat1_busy: busy=%b done0=%b, required busy=1 done0=0", l1_busy, l1_done0); end
        step();
        tests++; if (l1_done0 !== 1'b1) begin fails++; $display("FAIL lat1_done: got %b, required 1", l1_done0); end
        tests++; if (l1_result !== 32'h40C0_0000) begin fails++; $display("FAIL lat1_result: got %h, required 40c00000", l1_result); end
        wait_done(done_cnt + 1, ok);
        req0 = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL lat1_main_timeout: no done seen, required one"); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_operand_stability();
        test_reset_abort();
        test_reset_regrant();
        test_latency1();
        repeat (4) step();
        tests++; if (sb.size() !== 0) begin fails++; $display("FAIL scoreboard_left: got %0d pending, required 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving the number of BUSY cycles allowed for the multiplier; the legal range is 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  port-0 request; held high until done0.
REQ-005 a0, b0  input  32 each  port-0 IEEE-754 single operands.
REQ-006 req1  input  1  port-1 request; held high until done1.
REQ-007 a1, b1  input  32 each  port-1 operands.
REQ-008 done0, done1  output  1 each  one-cycle completion pulse per port.
REQ-009 result  output  32  registered product, valid while done0 or done1 is high.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 gnt_id  output  1  port currently granted; valid while busy.

Function
REQ-012 The block SHALL instantiate exactly one fp_mul, shared between both ports, and pass its output into result unmodified.
REQ-013 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-014 In IDLE with req0 or req1 high, the block SHALL grant a port and latch that port's operands into internal opa/opb registers.
- The FSM then moves to BUSY.
- A 4-bit counter loads LATENCY-1.
REQ-015 Arbitration SHALL be round-robin.
- If only one port requests, that port is granted.
- If both request, port rr_ptr is granted.
REQ-016 rr_ptr SHALL be set to the non-granted port on the RESP cycle.
REQ-017 fp_mul SHALL be driven only from opa/opb; changes on a*/b* after grant SHALL have no effect.
REQ-018 In BUSY, the counter SHALL decrement each cycle.
- When the counter is 0, the fp_mul output is captured into result and the FSM moves to RESP.
REQ-019 In RESP, the block SHALL raise done[gnt_id] for exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be exactly LATENCY+1 cycles from the grant cycle to the done cycle (3 cycles at the default).
REQ-021 No new grant SHALL occur in BUSY or RESP; requests arriving then SHALL wait, with no loss and no queueing beyond the held req level.
REQ-022 A requester SHALL drop req on the edge ending its done cycle.
- A req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-023 result SHALL hold its value until the next capture.
REQ-024 done0 and done1 SHALL never be high together.
REQ-025 The minimum issue interval SHALL be LATENCY+2 cycles, because one IDLE cycle separates consecutive operations.
REQ-026 With LATENCY=1, BUSY SHALL last exactly one cycle.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL go to IDLE with these values:
- rr_ptr=0, gnt_id=0, busy=0, done0=0, done1=0
- result=32'h0, counter=0, opa=0, opb=0
REQ-028 Reset SHALL take priority over every other transition.
REQ-029 Reset during BUSY or RESP SHALL abort the operation.
- No done pulse is issued for the aborted operation.
- A req still high after reset deasserts SHALL be regranted from IDLE, with port 0 preferred.

Verification
REQ-030 Single request: req0 with a0=32'h40000000, b0=32'h40400000 -> done0 3 cycles after grant, result=32'h40C00000, done1 stays 0.
REQ-031 Simultaneous requests after reset: req0 (1.0*1.0) and req1 (2.0*3.0) -> port 0 served first with result=32'h3F800000, then port 1 granted in the next IDLE cycle with result=32'h40C00000.
REQ-032 Fairness: req0 and req1 held continuously for 4 operations -> grant order is 0,1,0,1 and issues are spaced 4 cycles apart.
REQ-033 Operand stability: a0 changed to 32'h0 one cycle after grant -> result still equals the product of the latched operands.
REQ-034 Reset mid-BUSY: reset asserted on the second BUSY cycle -> no done pulse, busy=0 and result=0 the cycle after reset.
REQ-035 LATENCY=1 build: single request -> done 2 cycles after grant.
